lsu_mem_bridge: RTL



---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_mem_bridge_lane_align.sv | 33 +++
 rtl/lsu_mem_bridge.sv | 119 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory bridge: op bit positions,
// FSM state encoding and small op-decode helpers.
package lsu_pkg;

  localparam int OP_SB  = 0;
  localparam int OP_LB  = 1;
  localparam int OP_LBU = 2;
  localparam int OP_LH  = 3;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 5;
  localparam int OP_LD  = 6;
  localparam int OP_SW  = 7;
  localparam int OP_SD  = 8;
  localparam int OP_SH  = 9;
  localparam int OP_LWU = 10;
  localparam int OP_W   = 11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  function automatic logic [3:0] op_size(input logic [OP_W-1:0] op);
    logic [3:0] s;
    s = 4'd1;
    if (op[OP_LH] | op[OP_LHU] | op[OP_SH])
      s = 4'd2;
    else if (op[OP_LW] | op[OP_LWU] | op[OP_SW])
      s = 4'd4;
    else if (op[OP_LD] | op[OP_SD])
      s = 4'd8;
    return s;
  endfunction

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    return op[OP_SB] | op[OP_SH] | op[OP_SW] | op[OP_SD];
  endfunction

endpackage

// File: rtl/lsu_mem_bridge_lane_align.sv
// Byte-lane steering for the 64-bit data port: store data/strobe shifted
// up by the byte offset, load data shifted down to byte 0.
module lane_align (
  input  logic [2:0]  offset,
  input  logic [3:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata_in,
  output logic [63:0] wdata_sh,
  output logic [7:0]  strb,
  output logic [63:0] rdata_sh
);

  logic [5:0] bit_off;
  logic [7:0] base;

  assign bit_off = {offset, 3'b000};

  always_comb begin
    base = 8'h00;
    case (size)
      4'd1:    base = 8'h01;
      4'd2:    base = 8'h03;
      4'd4:    base = 8'h0F;
      4'd8:    base = 8'hFF;
      default: base = 8'h00;
    endcase
  end

  assign strb     = base << offset;
  assign wdata_sh = wdata << bit_off;
  assign rdata_sh = rdata_in >> bit_off;

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge to external data RAM: single outstanding valid/grant
// request, pipeline stall while in flight, misaligned accesses rejected.
//
// state | meaning
// IDLE  | waiting for an aligned one-hot request from EX
// REQ   | mem_req high with registered fields, waiting for mem_gnt
// WAIT  | granted, waiting for mem_rvalid (read data or write ack)
// RESP  | rdata_valid pulse, upstream released
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [10:0]       req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t      state, state_nxt;
  logic [3:0]  size_in;
  logic [2:0]  off_in, off_q, al_off;
  logic        op_onehot, aligned, offer, accept, reject;
  logic [63:0] wdata_sh, rdata_sh;
  logic [7:0]  strb;

  assign size_in   = op_size(req_op);
  assign off_in    = req_addr[2:0];
  assign op_onehot = (req_op != 11'd0) && ((req_op & (req_op - 11'd1)) == 11'd0);
  assign aligned   = (({1'b0, off_in} & (size_in - 4'd1)) == 4'd0);
  assign offer     = (state == IDLE) && req_valid && op_onehot;
  assign accept    = offer && aligned;
  assign reject    = offer && !aligned;

  // Shared aligner: request offset while idle, captured offset once in flight.
  assign al_off = (state == IDLE) ? off_in : off_q;

  lane_align u_lane_align (
    .offset   (al_off),
    .size     (size_in),
    .wdata    (req_wdata),
    .rdata_in (mem_rdata),
    .wdata_sh (wdata_sh),
    .strb     (strb),
    .rdata_sh (rdata_sh)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        rdata_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 8'h00;
      off_q     <= 3'd0;
      rdata     <= '0;
    end else begin
      misalign <= reject;
      if (accept) begin
        mem_we    <= op_is_store(req_op);
        mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
        mem_wdata <= wdata_sh;
        mem_wstrb <= op_is_store(req_op) ? strb : 8'h00;
        off_q     <= off_in;
      end
      // Write acks also arrive on mem_rvalid; only loads update rdata.
      if ((state == WAIT) && mem_rvalid && !mem_we)
        rdata <= rdata_sh;
    end
  end

endmodule
